mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter for the single shared memory port driven today by `cpu`. It sits between the CPU fetch/store path (requester 0) and a second bus master such as a program loader or DMA (requester 1), and serialises their transactions onto one memory interface. Arbitration is round-robin, the latency to memory is fixed, and each access is acknowledged per requester with a one-cycle `ack`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to valid `mem_rdata` (legal range 1..15)

Clock is `clock`; reset is `reset`, asynchronous and active-high.

- `clock`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0` / `req1`  in  1  transaction request; held high until `ack`
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  target address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `gnt0` / `gnt1`  out  1  requester owns the bus (ISSUE through ACK)
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read data; valid while `ack` is high, held afterwards
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  write qualifier, only meaningful with `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory for 1 cycle.
  - WAIT: count down `MEM_LAT` cycles.
  - ACK: pulse the completion to the owner.
- IDLE → ISSUE when any `req` is high. The arbiter latches the winner index, `we`, `addr` and `wdata` at that edge. With no request, it stays in IDLE.
- Winner selection:
  - If only one request is high, that requester wins regardless of priority.
  - If both are high, the requester named by the `prio` pointer wins.
- ISSUE: `mem_en`=1 and `mem_we`=latched `we`; `mem_addr`/`mem_wdata` carry the latched values. Next state is WAIT with the counter loaded to `MEM_LAT`-1.
- WAIT: the counter decrements each cycle. At the edge ending the cycle in which the counter is 0, the arbiter captures `mem_rdata` (reads only) and moves to ACK.
- ACK:
  - `ack` of the owner is 1; `rdata` of the owner shows the captured data.
  - `prio` is set to the non-served requester.
  - Next state is IDLE.
- Writes: `rdata` is not updated, and `ack` is still pulsed.
- `rdata0`/`rdata1` are separate registers; each changes only on its own read completion.
- `gnt` of the owner is high in ISSUE, WAIT and ACK, and low in IDLE. At most one `gnt` is high at a time.
- `mem_addr`/`mem_wdata`/`mem_we` hold the latched values from ISSUE through ACK and are 0 in IDLE.
- A `req` still high in the IDLE cycle after ACK is treated as a new transaction. A requester wanting exactly one access drops `req` during its ACK cycle.
- A requester dropping `req` before `ack` does not abort the transaction; it completes and acks normally.

## Timing
- Reset values:
  - state=IDLE, `prio`=0, and the WAIT counter is 0.
  - All outputs are 0, including `rdata0`/`rdata1`.
- Reset asserted mid-transaction: everything returns to the reset values immediately, and no `ack` is produced. A memory write already strobed is not undone.
- Latency, with the request first seen in IDLE at cycle t:
  - ISSUE at t+1.
  - WAIT at t+2..t+1+`MEM_LAT`.
  - ACK at t+2+`MEM_LAT`.
  - IDLE at t+3+`MEM_LAT`.
- Peak throughput is one transaction every `MEM_LAT`+3 cycles.
- Simultaneous requests: the loser's `req` stays pending and is served in the next IDLE cycle. With both held, service alternates 0,1,0,1 starting from `prio`.
- Changes to `addr`/`we`/`wdata` after the latching edge have no effect on the transaction in flight.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, ACK)
  - requester index constants `REQ_CPU`=0 and `REQ_AUX`=1
  - `MEM_LAT` upper bound constant (15)
- Sub-module `mem_arb_rr_pick`: combinational 2-way round-robin picker. Inputs are `req0`, `req1` and `prio`; outputs are `valid` and `winner`. Everything else is in the top-level FSM.

## Test plan
- Single read, `MEM_LAT`=1: `req0`=1, `we0`=0, `addr0`=0x10, memory returns 0xDEADBEEF → `mem_en` in cycle 1 with `mem_addr`=0x10, `ack0` and `rdata0`=0xDEADBEEF in cycle 3, `gnt0` high in cycles 1–3.
- Contention: `req0`=`req1`=1 held, reset `prio`=0 → service order 0,1,0,1, one `ack` every 4 cycles. `gnt0` and `gnt1` are never both high.
- Write: `req1`=1, `we1`=1, `addr1`=0x20, `wdata1`=0x12345678 → `mem_en`=`mem_we`=1, `mem_wdata`=0x12345678 in ISSUE; `ack1` pulses; `rdata1` keeps its previous value.
- Latency: `MEM_LAT`=3, single read → `ack0` exactly at t+5. The `mem_rdata` sampled is the value present in cycle t+4.
- Reset mid-WAIT: assert `reset` during WAIT → all outputs 0 within the same cycle, no `ack` after release, and the next lone `req1` is served with the normal latency.
- Back-to-back single requester: `req0` held across ACK → a second transaction starts, ISSUE 2 cycles after the first ACK.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   localparam int unsigned MEM_LAT_MAX = 15;
   localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request always wins,
// a tie goes to the requester named by prio.
module mem_arb_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic prio,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = req0 | req1;
      winner = (req0 & req1) ? prio : req1;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising two bus masters onto one fixed-latency
// memory port; each transaction runs IDLE -> ISSUE -> WAIT -> ACK.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               prio_q, prio_d;
   logic               owner_q, owner_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]  rdata0_q, rdata0_d;
   logic [DATA_W-1:0]  rdata1_q, rdata1_d;
   logic               gnt0_q, gnt0_d;
   logic               gnt1_q, gnt1_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               mem_en_q, mem_en_d;

   logic               pick_valid;
   logic               pick_winner;

   mem_arb_rr_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .prio   (prio_q),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // The memory-side registers double as the transaction latch: loaded on
   // the winning edge, held through ACK, cleared on the return to IDLE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prio_d      = prio_q;
      owner_d     = owner_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ISSUE;
               owner_d = pick_winner;
               if (pick_winner == REQ_AUX) begin
                  mem_we_d    = we1;
                  mem_addr_d  = addr1;
                  mem_wdata_d = wdata1;
               end else begin
                  mem_we_d    = we0;
                  mem_addr_d  = addr0;
                  mem_wdata_d = wdata0;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = ACK;
               if (!mem_we_q) begin
                  if (owner_q == REQ_AUX) rdata1_d = mem_rdata;
                  else                    rdata0_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            state_d     = IDLE;
            prio_d      = ~owner_q;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the next-state decode so they line up with the state.
      gnt0_d   = (state_d != IDLE) && (owner_d == REQ_CPU);
      gnt1_d   = (state_d != IDLE) && (owner_d == REQ_AUX);
      ack0_d   = (state_d == ACK)  && (owner_d == REQ_CPU);
      ack1_d   = (state_d == ACK)  && (owner_d == REQ_AUX);
      mem_en_d = (state_d == ISSUE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prio_q      <= REQ_CPU;
         owner_q     <= REQ_CPU;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prio_q      <= prio_d;
         owner_q     <= owner_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_en_q    <= mem_en_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table on a MEM_LAT=1
// instance plus hand sequences for reset-in-WAIT and MEM_LAT=3 latency.
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic        g0, g1, k0, k1, en, mwe;
      logic [31:0] maddr, mwd, rd0, rd1;
   } obs_t;

   typedef struct packed {
      logic [3:0]  rw;
      logic [31:0] a0, a1, d0, d1, mrd;
   } in_t;

   typedef struct packed {
      in_t  i;
      obs_t e;
   } vec_t;

   localparam logic [31:0] BD = 32'hBAD0BAD0;
   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] R0 = 32'h0A0A0A0A;
   localparam logic [31:0] R1 = 32'h1B1B1B1B;
   localparam logic [31:0] R2 = 32'h2C2C2C2C;
   localparam logic [31:0] R3 = 32'h3D3D3D3D;
   localparam logic [31:0] WD = 32'h12345678;
   localparam logic [31:0] XD = 32'hCAFEF00D;
   localparam logic [31:0] Z  = 32'h0;

   logic        clock, reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

   logic        g0_1, g1_1, k0_1, k1_1, en_1, we_1;
   logic [31:0] rd0_1, rd1_1, ma_1, mw_1;
   logic        g0_3, g1_3, k0_3, k1_3, en_3, we_3;
   logic [31:0] rd0_3, rd1_3, ma_3, mw_3;

   obs_t obs1, obs3;
   assign obs1 = {g0_1, g1_1, k0_1, k1_1, en_1, we_1, ma_1, mw_1, rd0_1, rd1_1};
   assign obs3 = {g0_3, g1_3, k0_3, k1_3, en_3, we_3, ma_3, mw_3, rd0_3, rd1_3};

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(g0_1), .gnt1(g1_1), .ack0(k0_1), .ack1(k1_1),
      .rdata0(rd0_1), .rdata1(rd1_1),
      .mem_en(en_1), .mem_we(we_1), .mem_addr(ma_1), .mem_wdata(mw_1),
      .mem_rdata(mem_rdata)
   );

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(g0_3), .gnt1(g1_3), .ack0(k0_3), .ack1(k1_3),
      .rdata0(rd0_3), .rdata1(rd1_3),
      .mem_en(en_3), .mem_we(we_3), .mem_addr(ma_3), .mem_wdata(mw_3),
      .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] rw, input logic [31:0] a0, a1, d0, d1, mrd,
                               input logic [5:0] fl, input logic [31:0] ma, mw, r0, r1);
      vec_t v;
      v.i = {rw, a0, a1, d0, d1, mrd};
      v.e = {fl, ma, mw, r0, r1};
      return v;
   endfunction

   task automatic drive(input in_t i);
      {req0, req1, we0, we1} = i.rw;
      addr0     = i.a0;
      addr1     = i.a1;
      wdata0    = i.d0;
      wdata1    = i.d1;
      mem_rdata = i.mrd;
   endtask

   vec_t vecs[$];

   initial begin
      // rw = {req0,req1,we0,we1}; flags = {gnt0,gnt1,ack0,ack1,mem_en,mem_we}
      // single read, req0 dropped before ack
      vecs.push_back(mk(4'b1000, 32'h10, Z, Z, Z, BD, 6'b000000, Z, Z, Z, Z));
      vecs.push_back(mk(4'b1000, 32'h10, Z, Z, Z, BD, 6'b100010, 32'h10, Z, Z, Z));
      vecs.push_back(mk(4'b0000, 32'h10, Z, Z, Z, DB, 6'b100000, 32'h10, Z, Z, Z));
      vecs.push_back(mk(4'b0000, 32'h10, Z, Z, Z, BD, 6'b101000, 32'h10, Z, DB, Z));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b000000, Z, Z, DB, Z));
      // write by requester 1; addr/wdata changed after latching
      vecs.push_back(mk(4'b0101, Z, 32'h20, Z, WD, BD, 6'b000000, Z, Z, DB, Z));
      vecs.push_back(mk(4'b0101, Z, 32'h99, Z, XD, BD, 6'b010011, 32'h20, WD, DB, Z));
      vecs.push_back(mk(4'b0101, Z, 32'h99, Z, XD, 32'h55555555, 6'b010001, 32'h20, WD, DB, Z));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b010101, 32'h20, WD, DB, Z));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b000000, Z, Z, DB, Z));
      // contention, both held: order 0,1,0,1
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b000000, Z, Z, DB, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b100010, 32'h100, Z, DB, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, R0, 6'b100000, 32'h100, Z, DB, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b101000, 32'h100, Z, R0, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b000000, Z, Z, R0, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b010010, 32'h200, Z, R0, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, R1, 6'b010000, 32'h200, Z, R0, Z));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b010100, 32'h200, Z, R0, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b000000, Z, Z, R0, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b100010, 32'h100, Z, R0, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, R2, 6'b100000, 32'h100, Z, R0, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b101000, 32'h100, Z, R2, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b000000, Z, Z, R2, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, BD, 6'b010010, 32'h200, Z, R2, R1));
      vecs.push_back(mk(4'b1100, 32'h100, 32'h200, Z, Z, R3, 6'b010000, 32'h200, Z, R2, R1));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b010100, 32'h200, Z, R2, R3));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b000000, Z, Z, R2, R3));
      // back-to-back on requester 0, req held across ACK
      vecs.push_back(mk(4'b1000, 32'h40, Z, Z, Z, BD, 6'b000000, Z, Z, R2, R3));
      vecs.push_back(mk(4'b1000, 32'h40, Z, Z, Z, BD, 6'b100010, 32'h40, Z, R2, R3));
      vecs.push_back(mk(4'b1000, 32'h40, Z, Z, Z, 32'h77, 6'b100000, 32'h40, Z, R2, R3));
      vecs.push_back(mk(4'b1000, 32'h40, Z, Z, Z, BD, 6'b101000, 32'h40, Z, 32'h77, R3));
      vecs.push_back(mk(4'b1000, 32'h44, Z, Z, Z, BD, 6'b000000, Z, Z, 32'h77, R3));
      vecs.push_back(mk(4'b1000, 32'h44, Z, Z, Z, BD, 6'b100010, 32'h44, Z, 32'h77, R3));
      vecs.push_back(mk(4'b1000, 32'h44, Z, Z, Z, 32'h88, 6'b100000, 32'h44, Z, 32'h77, R3));
      vecs.push_back(mk(4'b0000, 32'h44, Z, Z, Z, BD, 6'b101000, 32'h44, Z, 32'h88, R3));
      vecs.push_back(mk(4'b0000, Z, Z, Z, Z, BD, 6'b000000, Z, Z, 32'h88, R3));

      reset = 1'b1;
      drive('0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk_obs("reset_lat1", obs1, '0);
      chk_obs("reset_lat3", obs3, '0);

      foreach (vecs[n]) begin
         @(posedge clock); #1;
         drive(vecs[n].i);
         @(negedge clock);
         chk_obs($sformatf("vec%0d", n), obs1, vecs[n].e);
      end

      // reset asserted while dut1 is in WAIT
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         drive({4'b0100, Z, 32'h60, Z, Z, BD});
         @(negedge clock);
         chk32($sformatf("prerst_gnt1_c%0d", k), 32'(g1_1), 32'(k >= 1));
      end
      reset = 1'b1;
      req1  = 1'b0;
      #1;
      chk_obs("rst_async_lat1", obs1, '0);
      chk_obs("rst_async_lat3", obs3, '0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         @(negedge clock);
         chk_obs($sformatf("postrst_idle_c%0d", k), obs1, '0);
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         req1      = (k < 3);
         mem_rdata = 32'hF00D0000 + 32'(k);
         @(negedge clock);
         chk32($sformatf("postrst_ack1_c%0d", k), 32'(k1_1), 32'(k == 3));
         chk32($sformatf("postrst_gnt1_c%0d", k), 32'(g1_1), 32'(k >= 1 && k <= 3));
         if (k == 3) chk32("postrst_rdata1", rd1_1, 32'hF00D0002);
      end

      // MEM_LAT=3 latency on dut3
      @(posedge clock); #1 reset = 1'b1;
      drive('0);
      @(posedge clock); #1 reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         req0      = (k < 5);
         addr0     = 32'h30;
         mem_rdata = 32'hC0DE0000 + 32'(k);
         @(negedge clock);
         chk32($sformatf("lat3_ack0_c%0d", k), 32'(k0_3), 32'(k == 5));
         chk32($sformatf("lat3_en_c%0d", k), 32'(en_3), 32'(k == 1));
         chk32($sformatf("lat3_gnt0_c%0d", k), 32'(g0_3), 32'(k >= 1 && k <= 5));
         if (k == 5) chk32("lat3_rdata0", rd0_3, 32'hC0DE0004);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
